// File: rtl/system_pkg.sv
// Shared definitions for the dual-UART bridge: bit-period calculation and UART FSM states.
package system_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Clocks per serial bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_core.sv
// 8N1 UART: mid-bit sampling receiver with 2-flop synchronizer, and a one-byte transmitter.
module uart_core import system_pkg::*; #(
  parameter int DIV = 43
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  logic          rxd_meta_reg, rxd_sync_reg, rxd_last_reg;
  uart_state_t   rx_state_reg, rx_state_next;
  logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]    rx_bit_reg, rx_bit_next;
  logic [7:0]    rx_shift_reg, rx_shift_next;
  logic          rx_valid_reg, rx_valid_next;

  uart_state_t   tx_state_reg, tx_state_next;
  logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [7:0]    tx_shift_reg, tx_shift_next;
  logic          txd_reg, txd_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
      rxd_last_reg <= 1'b1;
      rx_state_reg <= IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_valid_reg <= 1'b0;
      tx_state_reg <= IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd_reg      <= 1'b1;
    end else begin
      rxd_meta_reg <= rxd;
      rxd_sync_reg <= rxd_meta_reg;
      rxd_last_reg <= rxd_sync_reg;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_valid_reg <= rx_valid_next;
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      txd_reg      <= txd_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg + 1'b1;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_valid_next = 1'b0;
    case (rx_state_reg)
      IDLE: begin
        rx_cnt_next = '0;
        rx_bit_next = '0;
        if (rxd_last_reg && !rxd_sync_reg) rx_state_next = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_state_next = rxd_sync_reg ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rxd_sync_reg, rx_shift_reg[7:1]};
          rx_bit_next   = rx_bit_reg + 3'd1;
          if (rx_bit_reg == 3'd7) rx_state_next = STOP;
        end
      end
      STOP: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_state_next = IDLE;
          rx_valid_next = rxd_sync_reg;
        end
      end
      default: rx_state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg + 1'b1;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    case (tx_state_reg)
      IDLE: begin
        tx_cnt_next = '0;
        tx_bit_next = '0;
        if (tx_start) begin
          tx_shift_next = tx_data;
          tx_state_next = START;
        end
      end
      START: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = DATA;
        end
      end
      DATA: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          tx_bit_next   = tx_bit_reg + 3'd1;
          if (tx_bit_reg == 3'd7) tx_state_next = STOP;
        end
      end
      STOP: begin
        if (tx_cnt_reg == BIT_LAST) tx_state_next = IDLE;
      end
      default: tx_state_next = IDLE;
    endcase
    // Line level is registered from the upcoming state so the pin never glitches.
    case (tx_state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = tx_shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

  assign txd      = txd_reg;
  assign tx_ready = (tx_state_reg == IDLE);
  assign rx_data  = rx_shift_reg;
  assign rx_valid = rx_valid_reg;

endmodule

// File: rtl/system.sv
// Sensor-node comms top: two UARTs cross-bridged through small FIFOs, LED toggles on UART0 rx.
module system import system_pkg::*; #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 115200,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic clk,
  input  logic rst,
  output logic led,
  input  logic uart_rxd,
  output logic uart_txd,
  input  logic uart_rxd1,
  output logic uart_txd1
);

  localparam int DIV = calc_div(clk_freq, uart_baud_rate);
  localparam int AW  = $clog2(FIFO_DEPTH);

  logic [1:0] rxd, txd, rx_valid, tx_start, tx_ready, fifo_pop;
  logic [7:0] rx_data   [2];
  logic [7:0] tx_data   [2];
  logic [7:0] fifo_head [2];
  logic       led_reg;

  assign rxd       = {uart_rxd1, uart_rxd};
  assign uart_txd  = txd[0];
  assign uart_txd1 = txd[1];

  // Lane gi owns UART gi and the FIFO carrying its received bytes to UART 1-gi.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] mem [FIFO_DEPTH];
      logic [AW:0] wr_ptr_reg, rd_ptr_reg;
      logic full, empty, push;

      uart_core #(.DIV(DIV)) u_uart (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd[gi]),
        .txd      (txd[gi]),
        .rx_data  (rx_data[gi]),
        .rx_valid (rx_valid[gi]),
        .tx_data  (tx_data[gi]),
        .tx_start (tx_start[gi]),
        .tx_ready (tx_ready[gi])
      );

      assign empty = (wr_ptr_reg == rd_ptr_reg);
      assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      assign fifo_pop[gi]  = !empty && tx_ready[1-gi];
      // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
      assign push          = rx_valid[gi] && (!full || fifo_pop[gi]);
      assign fifo_head[gi] = mem[rd_ptr_reg[AW-1:0]];

      assign tx_start[gi] = fifo_pop[1-gi];
      assign tx_data[gi]  = fifo_head[1-gi];

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= rx_data[gi];
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (push)         wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (fifo_pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst)             led_reg <= 1'b0;
    else if (rx_valid[0]) led_reg <= ~led_reg;
  end

  assign led = led_reg;

endmodule

// File: tb/tb_system.sv
// Bench for system: bit-level UART drivers, per-line frame monitors checking against expected-byte queues.
module tb_system;

  localparam int BIT = 43;

  logic clk, rst, led;
  logic uart_rxd, uart_txd, uart_rxd1, uart_txd1;

  typedef struct packed {
    logic [7:0] data;
    logic       chk_lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat_ref_cyc = 0;
  logic [1:0] mon_en = 2'b11;
  logic [1:0] busy = 2'b00;
  logic led_exp = 1'b0;

  system #(.clk_freq(50000000), .uart_baud_rate(1152000), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .led       (led),
    .uart_rxd  (uart_rxd),
    .uart_txd  (uart_txd),
    .uart_rxd1 (uart_rxd1),
    .uart_txd1 (uart_txd1)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 60000 cycles, required completion earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic line_of(input int ln);
    return (ln == 0) ? uart_txd : uart_txd1;
  endfunction

  task automatic expect_byte(input int ln, input logic [7:0] b, input logic lat);
    exp_t e;
    e.data = b;
    e.chk_lat = lat;
    if (ln == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  // Decodes frames on one DUT tx line and pops the scoreboard entry for each.
  task automatic monitor(input int ln);
    logic [7:0] b;
    logic start_mid, stop_bit;
    int fall_cyc, lat;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en[ln] && line_of(ln) === 1'b0) begin
        fall_cyc = cyc;
        busy[ln] = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        start_mid = line_of(ln);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = line_of(ln);
        end
        repeat (BIT) @(negedge clk);
        stop_bit = line_of(ln);
        checks++;
        if ((ln == 0 && q0.size() == 0) || (ln == 1 && q1.size() == 0)) begin
          errors++;
          $display("FAIL uart%0d_unexpected: got frame %02h, required no frame", ln, b);
        end else begin
          e = (ln == 0) ? q0.pop_front() : q1.pop_front();
          if (start_mid !== 1'b0 || stop_bit !== 1'b1 || b !== e.data) begin
            errors++;
            $display("FAIL uart%0d_byte: got %02h start=%b stop=%b, required %02h start=0 stop=1",
                     ln, b, start_mid, stop_bit, e.data);
          end else begin
            $display("uart%0d frame %02h ok", ln, b);
          end
          if (e.chk_lat) begin
            lat = fall_cyc - lat_ref_cyc;
            checks++;
            if (lat < BIT / 2 + 1 || lat > BIT / 2 + 6) begin
              errors++;
              $display("FAIL uart%0d_latency: start bit %0d clk after stop-bit drive, required %0d..%0d",
                       ln, lat, BIT / 2 + 1, BIT / 2 + 6);
            end
          end
        end
        busy[ln] = 1'b0;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic send(input int ln, input logic [7:0] b, input logic stop_val);
    logic [9:0] frame;
    frame = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == 9) lat_ref_cyc = cyc;
      if (ln == 0) uart_rxd = frame[i];
      else         uart_rxd1 = frame[i];
      repeat (BIT) @(negedge clk);
    end
    if (ln == 0) uart_rxd = 1'b1;
    else         uart_rxd1 = 1'b1;
    if (!stop_val) repeat (BIT) @(negedge clk);
    $display("sent uart%0d byte %02h stop=%b", ln, b, stop_val);
  endtask

  task automatic check_led(input string name);
    checks++;
    if (led !== led_exp) begin
      errors++;
      $display("FAIL %s_led: got %b, required %b", name, led, led_exp);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy != 2'b00) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: %0d/%0d bytes pending, required 0/0", name, q0.size(), q1.size());
    end
    repeat (60) @(negedge clk);
  endtask

  // Counts cycles where the lines are not idle-high or led differs from led_exp.
  task automatic quiet_window(input string name, input int n_cyc, input int rel_at);
    int bad0, bad1, badl;
    bad0 = 0; bad1 = 0; badl = 0;
    for (int i = 0; i < n_cyc; i++) begin
      if (i == rel_at) rst = 1'b1;
      @(negedge clk);
      if (uart_txd !== 1'b1)  bad0++;
      if (uart_txd1 !== 1'b1) bad1++;
      if (led !== led_exp)    badl++;
    end
    checks += 3;
    if (bad0 != 0) begin errors++; $display("FAIL %s_txd: %0d cycles not 1, required 0", name, bad0); end
    if (bad1 != 0) begin errors++; $display("FAIL %s_txd1: %0d cycles not 1, required 0", name, bad1); end
    if (badl != 0) begin errors++; $display("FAIL %s_led: %0d cycles not %b, required 0", name, badl, led_exp); end
  endtask

  initial begin
    uart_rxd  = 1'b1;
    uart_rxd1 = 1'b1;
    rst       = 1'b0;

    // 1: reset held 4 clk, then 1000 quiet clk
    quiet_window("reset", 1004, 4);

    // 2: 0x55 UART0 -> UART1 with latency bound
    expect_byte(1, 8'h55, 1'b1);
    send(0, 8'h55, 1'b1);
    led_exp = ~led_exp;
    check_led("t2");
    wait_drain("t2");

    // 3: 0xA3 UART1 -> UART0, led untouched
    expect_byte(0, 8'hA3, 1'b0);
    send(1, 8'hA3, 1'b1);
    check_led("t3");
    wait_drain("t3");

    // 4: six back-to-back bytes
    for (int i = 1; i <= 6; i++) expect_byte(1, 8'(i), 1'b0);
    for (int i = 1; i <= 6; i++) begin
      send(0, 8'(i), 1'b1);
      led_exp = ~led_exp;
      check_led("t4");
    end
    wait_drain("t4");

    // 5: framing error dropped, then 0x7E passes
    send(0, 8'h3C, 1'b0);
    check_led("t5_bad");
    expect_byte(1, 8'h7E, 1'b0);
    send(0, 8'h7E, 1'b1);
    led_exp = ~led_exp;
    check_led("t5_good");
    wait_drain("t5");

    // 6: reset mid-way through a uart_txd1 frame
    mon_en[1] = 1'b0;
    send(0, 8'h00, 1'b1);
    repeat (80) @(negedge clk);
    checks++;
    if (uart_txd1 !== 1'b0) begin
      errors++;
      $display("FAIL t6_midframe: txd1=%b, required 0", uart_txd1);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (uart_txd1 !== 1'b1) begin
      errors++;
      $display("FAIL t6_abort: txd1=%b, required 1", uart_txd1);
    end
    led_exp = 1'b0;
    quiet_window("t6_after", 1000, 0);
    mon_en[1] = 1'b1;
    expect_byte(1, 8'h42, 1'b0);
    send(0, 8'h42, 1'b1);
    led_exp = ~led_exp;
    check_led("t6_resume");
    wait_drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
